bg_stream_buffer: RTL
=====================

// Module: bg_stream_buffer
// PURPOSE
//  Writable, parametrised successor to the fixed bias/gate constant table in the LSTM datapath.
//  Holds DEPTH vectors of UNITS_NUM x D_WL words; a loader writes one lane word per cycle.
//  A sequencer streams a base/count window of vectors to the gate MAC array.
//  The stream has valid/ready backpressure, wrap-around addressing and a done pulse.
// PARAMETERS
//  D_WL       24  bit width of one bias/gate word (two's complement)
//  UNITS_NUM  5   words (lanes) per vector
//  DEPTH      6   number of stored vectors (>=2)
//  AW         $clog2(DEPTH)      localparam: vector address width
//  LW         $clog2(UNITS_NUM)  localparam: lane index width (min 1)
// PORTS
//  clk      in   1               rising-edge clock
//  rst      in   1               synchronous, active-high reset
//  wr_en    in   1               write one lane word this cycle
//  wr_addr  in   AW              target vector
//  wr_lane  in   LW              target lane; lane 0 = bits [D_WL-1:0]
//  wr_data  in   D_WL            word to store
//  start    in   1               launch stream (ignored while busy)
//  base     in   AW              first vector of window
//  count    in   AW+1            vectors to stream, 0..DEPTH
//  busy     out  1               stream in progress
//  done     out  1               one-cycle pulse: stream finished
//  o_valid  out  1               w_o/o_addr/o_last valid
//  o_ready  in   1               consumer accepts beat
//  w_o      out  UNITS_NUM*D_WL  streamed vector
//  o_addr   out  AW              vector index of current beat
//  o_last   out  1               current beat is final of window
// BEHAVIOUR
//  - Reset: memory all zero; busy=0, done=0, o_valid=0, w_o=0, o_addr=0, o_last=0; FSM->IDLE.
//  - Reset mid-stream aborts: no done pulse; outputs cleared on that edge.
//  - Write: on edge with wr_en, mem[wr_addr][wr_lane] <= wr_data.
//    Writes with wr_addr>=DEPTH or wr_lane>=UNITS_NUM are dropped.
//  - Writes are legal in any state, including during a stream.
//  - Read-during-write to the same vector on one edge: the output register takes the OLD contents.
//  - FSM IDLE -> RUN on start with count>0.
//    The start edge loads beat 0 (mem[base]) into the output register.
//    o_valid=1 from the next cycle: one-cycle start-to-data latency.
//  - start with count==0: stay IDLE, no beats, done pulses the next cycle, busy stays 0.
//  - RUN: a beat is accepted when o_valid&&o_ready. On that edge:
//    - If beats remain, load the next vector; o_valid stays 1. Throughput: 1 beat/clk.
//    - Else o_valid<=0, FSM->IDLE.
//  - Output stability: w_o/o_addr/o_last are held stable while o_valid&&!o_ready.
//  - Addressing: next addr = (addr==DEPTH-1) ? 0 : addr+1, i.e. modulo DEPTH.
//    base>=DEPTH is clamped to 0.
//  - o_last=1 exactly on beat count-1.
//  - busy=1 from the cycle after start through the cycle holding the last beat.
//  - done=1 for one cycle after the last handshake, concurrent with busy falling.
//  - start while busy has no effect.
//  - start in the same cycle as done is accepted.
// STRUCTURE
//  - Package bg_pkg: D_WL, UNITS_NUM, DEPTH defaults; AW/LW derivation functions;
//    FSM state enum {IDLE,RUN}.
//  - Sub-module bg_mem: DEPTH x UNITS_NUM register array with sync clear,
//    lane-granular write and combinational index read.
//  - Top holds the FSM, address/remaining counters and the output register.
// TESTING
//  1. Reset, then write all 30 lanes with value {addr,lane}, start base=0,count=6, o_ready=1
//     -> 6 beats on consecutive cycles, addr 0..5, o_last on beat 5, done one cycle later.
//  2. base=4,count=4 -> o_addr sequence 4,5,0,1; o_last on addr 1.
//  3. o_ready low for 3 cycles on beat 1 -> w_o/o_addr stable, no beat lost or duplicated.
//  4. count=0 -> no o_valid, busy=0, done pulses one cycle after start.
//  5. Write vector 2 lane 3 = 'hABCDEF on the edge it is loaded -> beat shows old value.
//     Re-stream -> 'hABCDEF in bits [4*D_WL-1:3*D_WL].
//  6. Assert rst mid-stream (beat 2) -> outputs and memory zero next cycle, no done pulse.
//     start ignored while busy; start accepted in the done cycle.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared defaults, width helpers and FSM state type for the bias/gate stream buffer.
package bg_pkg;

  localparam int D_WL_DEF      = 24;
  localparam int UNITS_NUM_DEF = 5;
  localparam int DEPTH_DEF     = 6;

  // Index width for n entries. Returns at least 1 so that an index port is
  // never zero bits wide.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bg_state_e;

endpackage

// File: rtl/bg_mem.sv
// DEPTH x UNITS_NUM word store. Each write updates one lane of one vector.
// Reads return a whole vector combinationally.
module bg_mem
  import bg_pkg::*;
#(
  parameter int D_WL      = D_WL_DEF,
  parameter int UNITS_NUM = UNITS_NUM_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AW        = clog2_min1(DEPTH),
  parameter int LW        = clog2_min1(UNITS_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [AW-1:0]             wr_addr_i,
  input  logic [LW-1:0]             wr_lane_i,
  input  logic [D_WL-1:0]           wr_data_i,
  input  logic [AW-1:0]             rd_addr_i,
  output logic [UNITS_NUM*D_WL-1:0] rd_data_o
);

  logic [DEPTH-1:0][UNITS_NUM-1:0][D_WL-1:0] mem_q;

  // Lane-granular write. An out-of-range address or lane matches no entry,
  // so that write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        for (int l = 0; l < UNITS_NUM; l++) begin
          if (wr_en_i && (wr_addr_i == AW'(a)) && (wr_lane_i == LW'(l)))
            mem_q[a][l] <= wr_data_i;
        end
      end
    end
  end

  // Whole-vector read mux. The read sees the contents present before this
  // edge's write.
  always_comb begin
    rd_data_o = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (rd_addr_i == AW'(a))
        rd_data_o = mem_q[a];
    end
  end

endmodule

// File: rtl/bg_stream_buffer.sv
// Writable bias/gate vector table. It streams a base/count window of vectors
// to the gate MAC array over a valid/ready port, with wrap-around addressing
// and a done pulse.
module bg_stream_buffer
  import bg_pkg::*;
#(
  parameter  int D_WL      = D_WL_DEF,
  parameter  int UNITS_NUM = UNITS_NUM_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  localparam int AW        = clog2_min1(DEPTH),
  localparam int LW        = clog2_min1(UNITS_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [LW-1:0]             wr_lane,
  input  logic [D_WL-1:0]           wr_data,
  input  logic                      start,
  input  logic [AW-1:0]             base,
  input  logic [AW:0]               count,
  output logic                      busy,
  output logic                      done,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [UNITS_NUM*D_WL-1:0] w_o,
  output logic [AW-1:0]             o_addr,
  output logic                      o_last
);

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  bg_state_e                 state_q, state_d;
  logic [UNITS_NUM*D_WL-1:0] w_q, w_d, rd_data;
  logic [AW-1:0]             addr_q, addr_d, addr_nxt, base_c, rd_addr;
  logic [AW:0]               rem_q, rem_d;   // beats left after the one on the port
  logic                      valid_q, valid_d, last_q, last_d, done_q, done_d;

  assign base_c   = ({1'b0, base} < DEPTH_C) ? base : '0;
  assign addr_nxt = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
  // In IDLE the read port looks up the window head so that the start edge
  // can load beat 0. In RUN it looks up the vector that follows the current beat.
  assign rd_addr  = (state_q == RUN) ? addr_nxt : base_c;

  bg_mem #(
    .D_WL(D_WL), .UNITS_NUM(UNITS_NUM), .DEPTH(DEPTH), .AW(AW), .LW(LW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_lane_i (wr_lane),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Sequencer next state. Output-register fields load only on the start edge
  // or on a handshake edge, so they hold while the consumer stalls.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            w_d     = rd_data;
            addr_d  = base_c;
            rem_d   = count - (AW+1)'(1);
            last_d  = (count == (AW+1)'(1));
          end
        end
      end
      RUN: begin
        if (valid_q && o_ready) begin
          if (rem_q != '0) begin
            w_d    = rd_data;
            addr_d = addr_nxt;
            rem_d  = rem_q - (AW+1)'(1);
            last_d = (rem_q == (AW+1)'(1));
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register. Reset aborts any stream without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign o_valid = valid_q;
  assign w_o     = w_q;
  assign o_addr  = addr_q;
  assign o_last  = last_q;

endmodule
